// File: rtl/logic_axi4_stream_mux_arbiter.sv
// rtl/logic_axi4_stream_mux_arbiter.sv - packet-level round-robin AXI4-Stream mux
//
// Purpose:
//   Shares one AXI4-Stream Tx channel between INPUTS Rx requesters. The
//   grant is held for a whole packet (until the tlast beat is accepted), so
//   beats from different sources never interleave on tx. After a packet
//   completes, its source drops to lowest priority. A single registered
//   output stage gives 1-cycle latency at full throughput.
//
// Ports:
//   aclk, areset_n       clock, asynchronous active-low reset
//   rx_t*  [INPUTS]      Rx bundles, flattened: source i occupies slice i
//   rx_tready [INPUTS]   per-source ready (combinational)
//   tx_t*                registered Tx bundle; disabled tkeep/tstrb/tlast
//                        are driven constant 1
module logic_axi4_stream_mux_arbiter #(
  parameter int INPUTS      = 2,
  parameter int TDATA_BYTES = 1,
  parameter int TDEST_WIDTH = 1,
  parameter int TUSER_WIDTH = 1,
  parameter int TID_WIDTH   = 1,
  parameter bit USE_TKEEP   = 1'b1,
  parameter bit USE_TSTRB   = 1'b1,
  parameter bit USE_TLAST   = 1'b1
) (
  input  logic                             aclk,
  input  logic                             areset_n,
  input  logic [INPUTS-1:0]                rx_tvalid,
  output logic [INPUTS-1:0]                rx_tready,
  input  logic [INPUTS*TDATA_BYTES*8-1:0]  rx_tdata,
  input  logic [INPUTS*TDATA_BYTES-1:0]    rx_tkeep,
  input  logic [INPUTS*TDATA_BYTES-1:0]    rx_tstrb,
  input  logic [INPUTS-1:0]                rx_tlast,
  input  logic [INPUTS*TDEST_WIDTH-1:0]    rx_tdest,
  input  logic [INPUTS*TUSER_WIDTH-1:0]    rx_tuser,
  input  logic [INPUTS*TID_WIDTH-1:0]      rx_tid,
  output logic                             tx_tvalid,
  input  logic                             tx_tready,
  output logic [TDATA_BYTES*8-1:0]         tx_tdata,
  output logic [TDATA_BYTES-1:0]           tx_tkeep,
  output logic [TDATA_BYTES-1:0]           tx_tstrb,
  output logic                             tx_tlast,
  output logic [TDEST_WIDTH-1:0]           tx_tdest,
  output logic [TUSER_WIDTH-1:0]           tx_tuser,
  output logic [TID_WIDTH-1:0]             tx_tid
);

  localparam int DW = TDATA_BYTES * 8;
  localparam int KW = TDATA_BYTES;
  localparam int IW = (INPUTS > 1) ? $clog2(INPUTS) : 1;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  logic [0:0]             state_q, state_d;
  logic [IW-1:0]          ptr_q, ptr_d;
  logic [IW-1:0]          grant_q, grant_d;
  logic                   tvalid_q, tvalid_d;
  logic [DW-1:0]          tdata_q, tdata_d;
  logic [KW-1:0]          tkeep_q, tkeep_d;
  logic [KW-1:0]          tstrb_q, tstrb_d;
  logic                   tlast_q, tlast_d;
  logic [TDEST_WIDTH-1:0] tdest_q, tdest_d;
  logic [TUSER_WIDTH-1:0] tuser_q, tuser_d;
  logic [TID_WIDTH-1:0]   tid_q, tid_d;

  logic          ca;
  logic          found;
  logic [IW-1:0] winner;
  logic [IW-1:0] sel;
  logic          sel_req;
  logic          fire;
  logic          beat_last;
  logic [IW-1:0] ptr_next;
  int            cand;

  // Round-robin search starting at the pointer, wrapping at INPUTS.
  always_comb begin
    found  = 1'b0;
    winner = ptr_q;
    cand   = 0;
    for (int k = 0; k < INPUTS; k++) begin
      cand = (int'(ptr_q) + k) % INPUTS;
      if (!found && rx_tvalid[cand]) begin
        found  = 1'b1;
        winner = IW'(cand);
      end
    end
  end

  always_comb begin
    ca = !tvalid_q || tx_tready;

    // While locked, the granted source keeps ready even if it is not valid,
    // which is what holds other sources off during a mid-packet gap.
    sel     = (state_q == ST_LOCKED) ? grant_q : winner;
    sel_req = (state_q == ST_LOCKED) ? 1'b1 : found;

    rx_tready = '0;
    if (areset_n && sel_req && ca) begin
      rx_tready[sel] = 1'b1;
    end
    fire = areset_n && sel_req && ca && rx_tvalid[sel];

    beat_last = (USE_TLAST != 1'b0) ? rx_tlast[sel] : 1'b1;
    ptr_next  = (sel == IW'(INPUTS - 1)) ? '0 : sel + 1'b1;

    state_d  = state_q;
    ptr_d    = ptr_q;
    grant_d  = grant_q;
    tvalid_d = tvalid_q && !tx_tready;
    tdata_d  = tdata_q;
    tkeep_d  = tkeep_q;
    tstrb_d  = tstrb_q;
    tlast_d  = tlast_q;
    tdest_d  = tdest_q;
    tuser_d  = tuser_q;
    tid_d    = tid_q;

    if (fire) begin
      tvalid_d = 1'b1;
      tdata_d  = rx_tdata[sel*DW +: DW];
      tkeep_d  = rx_tkeep[sel*KW +: KW];
      tstrb_d  = rx_tstrb[sel*KW +: KW];
      tlast_d  = beat_last;
      tdest_d  = rx_tdest[sel*TDEST_WIDTH +: TDEST_WIDTH];
      tuser_d  = rx_tuser[sel*TUSER_WIDTH +: TUSER_WIDTH];
      tid_d    = rx_tid[sel*TID_WIDTH +: TID_WIDTH];
      grant_d  = sel;
      if (beat_last) begin
        state_d = ST_IDLE;
        ptr_d   = ptr_next;
      end else begin
        state_d = ST_LOCKED;
      end
    end
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      grant_q  <= '0;
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      tkeep_q  <= '0;
      tstrb_q  <= '0;
      tlast_q  <= 1'b0;
      tdest_q  <= '0;
      tuser_q  <= '0;
      tid_q    <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      grant_q  <= grant_d;
      tvalid_q <= tvalid_d;
      tdata_q  <= tdata_d;
      tkeep_q  <= tkeep_d;
      tstrb_q  <= tstrb_d;
      tlast_q  <= tlast_d;
      tdest_q  <= tdest_d;
      tuser_q  <= tuser_d;
      tid_q    <= tid_d;
    end
  end

  assign tx_tvalid = tvalid_q;
  assign tx_tdata  = tdata_q;
  assign tx_tkeep  = (USE_TKEEP != 1'b0) ? tkeep_q : {KW{1'b1}};
  assign tx_tstrb  = (USE_TSTRB != 1'b0) ? tstrb_q : {KW{1'b1}};
  assign tx_tlast  = (USE_TLAST != 1'b0) ? tlast_q : 1'b1;
  assign tx_tdest  = tdest_q;
  assign tx_tuser  = tuser_q;
  assign tx_tid    = tid_q;

endmodule

// File: tb/tb_logic_axi4_stream_mux_arbiter.sv
// tb/tb_logic_axi4_stream_mux_arbiter.sv - bench for the packet round-robin stream mux
module tb_logic_axi4_stream_mux_arbiter;

  logic aclk = 1'b0;
  always #5 aclk = ~aclk;
  logic areset_n;

  // 4-input instance, tlast enabled
  logic [3:0]  rx_tvalid, rx_tready, rx_tkeep, rx_tstrb, rx_tlast, rx_tuser;
  logic [31:0] rx_tdata;
  logic [7:0]  rx_tdest, rx_tid;
  logic        tx_tvalid, tx_tready, tx_tlast, tx_tuser;
  logic [7:0]  tx_tdata;
  logic [0:0]  tx_tkeep, tx_tstrb;
  logic [1:0]  tx_tdest, tx_tid;

  // 2-input instance, tlast disabled
  logic [1:0]  n_rx_tvalid, n_rx_tready, n_rx_tkeep, n_rx_tstrb, n_rx_tlast;
  logic [1:0]  n_rx_tdest, n_rx_tuser, n_rx_tid;
  logic [15:0] n_rx_tdata;
  logic        n_tx_tvalid, n_tx_tready, n_tx_tlast;
  logic [7:0]  n_tx_tdata;
  logic [0:0]  n_tx_tkeep, n_tx_tstrb, n_tx_tdest, n_tx_tuser, n_tx_tid;

  logic_axi4_stream_mux_arbiter #(
    .INPUTS(4), .TDATA_BYTES(1), .TDEST_WIDTH(2), .TUSER_WIDTH(1), .TID_WIDTH(2),
    .USE_TKEEP(1'b1), .USE_TSTRB(1'b1), .USE_TLAST(1'b1)
  ) dut (
    .aclk(aclk), .areset_n(areset_n),
    .rx_tvalid(rx_tvalid), .rx_tready(rx_tready), .rx_tdata(rx_tdata),
    .rx_tkeep(rx_tkeep), .rx_tstrb(rx_tstrb), .rx_tlast(rx_tlast),
    .rx_tdest(rx_tdest), .rx_tuser(rx_tuser), .rx_tid(rx_tid),
    .tx_tvalid(tx_tvalid), .tx_tready(tx_tready), .tx_tdata(tx_tdata),
    .tx_tkeep(tx_tkeep), .tx_tstrb(tx_tstrb), .tx_tlast(tx_tlast),
    .tx_tdest(tx_tdest), .tx_tuser(tx_tuser), .tx_tid(tx_tid)
  );

  logic_axi4_stream_mux_arbiter #(
    .INPUTS(2), .TDATA_BYTES(1), .TDEST_WIDTH(1), .TUSER_WIDTH(1), .TID_WIDTH(1),
    .USE_TKEEP(1'b1), .USE_TSTRB(1'b1), .USE_TLAST(1'b0)
  ) dut_nl (
    .aclk(aclk), .areset_n(areset_n),
    .rx_tvalid(n_rx_tvalid), .rx_tready(n_rx_tready), .rx_tdata(n_rx_tdata),
    .rx_tkeep(n_rx_tkeep), .rx_tstrb(n_rx_tstrb), .rx_tlast(n_rx_tlast),
    .rx_tdest(n_rx_tdest), .rx_tuser(n_rx_tuser), .rx_tid(n_rx_tid),
    .tx_tvalid(n_tx_tvalid), .tx_tready(n_tx_tready), .tx_tdata(n_tx_tdata),
    .tx_tkeep(n_tx_tkeep), .tx_tstrb(n_tx_tstrb), .tx_tlast(n_tx_tlast),
    .tx_tdest(n_tx_tdest), .tx_tuser(n_tx_tuser), .tx_tid(n_tx_tid)
  );

  int errors = 0;
  int checks = 0;

  // Source model: source i sends total[i] beats, grouped in packets of plen[i].
  int         total[4];
  int         sent[4];
  int         plen[4];
  logic [7:0] base[4];
  bit         hold[4];

  logic [15:0] exp_q[$];
  logic [7:0]  nq[$];
  logic [3:0]  acc;
  int          hs_cnt;
  bit          prev_stall;
  logic [15:0] prev_obs;
  bit          nl_en;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // {tdata, tlast, tid, tdest, tuser, tkeep, tstrb}
  function automatic logic [15:0] mk(input int s, input int b);
    logic [7:0]  d;
    logic        l;
    logic [31:0] bb, ss;
    bb = b;
    ss = s;
    d  = base[s] + bb[7:0];
    l  = ((b % plen[s]) == plen[s] - 1);
    return {d, l, ss[1:0], ss[1:0], bb[0], ss[0], ~ss[0]};
  endfunction

  task automatic push_pkt(input int s, input int first, input int n);
    for (int b = first; b < first + n; b++) exp_q.push_back(mk(s, b));
  endtask

  task automatic update_drive();
    logic [15:0] e;
    for (int i = 0; i < 4; i++) begin
      if (sent[i] < total[i] && !hold[i]) begin
        e = mk(i, sent[i]);
        rx_tvalid[i]      = 1'b1;
        rx_tdata[i*8 +: 8] = e[15:8];
        rx_tlast[i]       = e[7];
        rx_tid[i*2 +: 2]  = e[6:5];
        rx_tdest[i*2 +: 2] = e[4:3];
        rx_tuser[i]       = e[2];
        rx_tkeep[i]       = e[1];
        rx_tstrb[i]       = e[0];
      end else begin
        rx_tvalid[i]       = 1'b0;
        rx_tdata[i*8 +: 8] = 8'hEE;
      end
    end
  endtask

  task automatic clr_src();
    for (int i = 0; i < 4; i++) begin
      total[i] = 0;
      sent[i]  = 0;
      plen[i]  = 1;
      hold[i]  = 1'b0;
      base[i]  = 8'(i * 64);
    end
  endtask

  // Samples at the falling edge, then advances sources after the rising edge.
  task automatic tick();
    logic [15:0] o;
    logic [15:0] e;
    logic [7:0]  ne;
    @(negedge aclk);
    acc = rx_tvalid & rx_tready;
    o = {tx_tdata, tx_tlast, tx_tid, tx_tdest, tx_tuser, tx_tkeep, tx_tstrb};
    if (prev_stall) chk("stall_payload_stable", o, prev_obs);
    if (tx_tvalid && !tx_tready) begin
      chk("stall_rx_tready", rx_tready, 4'b0000);
      prev_stall = 1'b1;
      prev_obs   = o;
    end else begin
      prev_stall = 1'b0;
    end
    if (tx_tvalid && tx_tready) begin
      hs_cnt++;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
      chk("sb_beat", o, e);
    end
    if (nl_en && n_tx_tvalid) begin
      ne = (nq.size() > 0) ? nq.pop_front() : 8'hxx;
      chk("nl_beat", {n_tx_tdata, n_tx_tlast}, {ne, 1'b1});
    end
    @(posedge aclk);
    #1;
    for (int i = 0; i < 4; i++) if (acc[i]) sent[i]++;
    update_drive();
  endtask

  task automatic drain();
    for (int k = 0; k < 200; k++) begin
      if (exp_q.size() == 0 && !tx_tvalid) break;
      tick();
    end
    chk("drain_empty", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    areset_n = 1'b0;
    clr_src();
    update_drive();
    tx_tready   = 1'b1;
    n_rx_tvalid = 2'b00;
    repeat (2) @(posedge aclk);
    #1;
    exp_q.delete();
    prev_stall = 1'b0;
    areset_n   = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    areset_n    = 1'b0;
    rx_tvalid   = '0; rx_tdata = '0; rx_tkeep = '0; rx_tstrb = '0;
    rx_tlast    = '0; rx_tdest = '0; rx_tuser = '0; rx_tid = '0;
    tx_tready   = 1'b1;
    n_rx_tvalid = '0; n_rx_tdata = {8'h01, 8'h00}; n_rx_tkeep = '1; n_rx_tstrb = '1;
    n_rx_tlast  = '0; n_rx_tdest = 2'b10; n_rx_tuser = '0; n_rx_tid = 2'b10;
    n_tx_tready = 1'b1;
    nl_en = 1'b0; hs_cnt = 0; prev_stall = 1'b0; prev_obs = '0; acc = '0;
    clr_src();
    update_drive();

    // 1: reset state, single beat latency, pointer advance past source 2
    #12;
    chk("rst_tx_tvalid", tx_tvalid, 1'b0);
    chk("rst_rx_tready", rx_tready, 4'b0000);
    chk("rst_tx_tdata", tx_tdata, 8'h00);
    chk("rst_nl_tx_tvalid", n_tx_tvalid, 1'b0);
    @(posedge aclk);
    #1;
    areset_n = 1'b1;
    base[2]  = 8'h5A;
    total[2] = 1;
    push_pkt(2, 0, 1);
    update_drive();
    chk("t1_pre_tx_tvalid", tx_tvalid, 1'b0);
    tick();
    chk("t1_accept", acc, 4'b0100);
    chk("t1_lat_tvalid", tx_tvalid, 1'b1);
    chk("t1_lat_tdata", tx_tdata, 8'h5A);
    for (int i = 0; i < 4; i++) total[i] = sent[i] + 1;
    push_pkt(3, 0, 1);
    push_pkt(0, 0, 1);
    push_pkt(1, 0, 1);
    push_pkt(2, 1, 1);
    update_drive();
    drain();

    // 2: all sources valid, 3-beat packets, full rate
    do_reset();
    for (int i = 0; i < 4; i++) begin
      plen[i]  = 3;
      total[i] = (i == 0) ? 6 : 3;
    end
    push_pkt(0, 0, 3);
    push_pkt(1, 0, 3);
    push_pkt(2, 0, 3);
    push_pkt(3, 0, 3);
    push_pkt(0, 3, 3);
    update_drive();
    tick();
    hs_cnt = 0;
    repeat (12) tick();
    chk("t2_beats_in_12", hs_cnt, 12);
    drain();

    // 3: granted source stalls mid-packet, others must wait
    do_reset();
    plen[1] = 4; total[1] = 4;
    plen[0] = 1; plen[3] = 1;
    push_pkt(1, 0, 4);
    push_pkt(3, 0, 1);
    push_pkt(0, 0, 1);
    update_drive();
    tick();
    total[0] = 1;
    total[3] = 1;
    update_drive();
    tick();
    chk("t3_sent_before_gap", sent[1], 2);
    hold[1] = 1'b1;
    update_drive();
    for (int c = 0; c < 5; c++) begin
      tick();
      #1;
      chk("t3_locked_ready", {rx_tready[3], rx_tready[0]}, 2'b00);
    end
    hold[1] = 1'b0;
    update_drive();
    drain();

    // 4: tx backpressure pattern 1,0,0,1 inside a 4-beat packet
    do_reset();
    plen[0] = 4; total[0] = 4;
    push_pkt(0, 0, 4);
    update_drive();
    tick();
    tx_tready = 1'b1; tick();
    tx_tready = 1'b0; tick();
    tx_tready = 1'b0; tick();
    tx_tready = 1'b1; tick();
    drain();

    // 5: tlast disabled, two always-valid sources alternate per beat
    do_reset();
    n_rx_tvalid = 2'b11;
    for (int k = 0; k < 6; k++) nq.push_back(8'(k % 2));
    nl_en = 1'b1;
    repeat (7) tick();
    nl_en = 1'b0;
    chk("t5_nl_drained", nq.size(), 0);
    n_rx_tvalid = 2'b00;

    // 6: asynchronous reset mid-packet drops it and restarts from pointer 0
    do_reset();
    plen[1] = 1; total[1] = 1;
    push_pkt(1, 0, 1);
    update_drive();
    drain();
    plen[3] = 4; total[3] = 4;
    push_pkt(3, 0, 1);
    update_drive();
    tick();
    tick();
    chk("t6_mid_tvalid", tx_tvalid, 1'b1);
    #2;
    areset_n = 1'b0;
    #1;
    chk("t6_async_tvalid", tx_tvalid, 1'b0);
    chk("t6_async_ready", rx_tready, 4'b0000);
    chk("t6_sb_before_drop", exp_q.size(), 0);
    clr_src();
    update_drive();
    exp_q.delete();
    prev_stall = 1'b0;
    @(posedge aclk);
    #1;
    areset_n = 1'b1;
    total[0] = 1;
    total[3] = 1;
    push_pkt(0, 0, 1);
    push_pkt(3, 0, 1);
    update_drive();
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/logic_axi4_stream_mux_arbiter.md
Name: logic_axi4_stream_mux_arbiter

Overview:
- Packet-level round-robin arbiter: shares one AXI4-Stream Tx channel between INPUTS Rx requesters.
- Functional inverse of the tdest/tid demultiplexer. Typically placed in front of a shared sink, e.g. a single stream feeding a demux tree.
- Grant is locked for a whole packet (until tlast is accepted), so beats from different sources never interleave.
- One registered output stage: full throughput, 1-cycle latency.

Parameters:
- INPUTS, 2: number of Rx requesters; must be ≥ 1.
- TDATA_BYTES, 1: bytes of tdata.
- TDEST_WIDTH, 1: bits of tdest.
- TUSER_WIDTH, 1: bits of tuser.
- TID_WIDTH, 1: bits of tid.
- USE_TKEEP, 1: enable tkeep.
- USE_TSTRB, 1: enable tstrb.
- USE_TLAST, 1: enable tlast; when 0, every beat is a one-beat packet (per-beat arbitration).

Ports:
- aclk  input  1  clock.
- areset_n  input  1  reset: asynchronous, active-low.
- rx  input (interface array)  [INPUTS]  AXI4-Stream Rx bundles: tvalid, tready (out), tdata, tkeep, tstrb, tlast, tdest, tuser, tid.
- tx  output (interface)  1  AXI4-Stream Tx bundle, same signal set, widths per parameters.

Behaviour:
- Reset values: tx.tvalid=0; all rx[i].tready=0; tx payload registers=0; state=IDLE; rr pointer=0; grant index=0.
- Output register "can accept" (ca) = !tx.tvalid || tx.tready. Loads a beat when the granted rx handshake fires.
- tx.tvalid stays set until tx.tready. Payload stays stable while tx.tvalid && !tx.tready.
- FSM IDLE:
  - Winner = first i with rx[i].tvalid, searching pointer, pointer+1, …, INPUTS-1, wrapping to 0.
  - rx[winner].tready = ca, combinational on valid; no idle cycle, so back-to-back packets run at full rate.
  - All other rx[i].tready=0.
  - On handshake: load beat into output, latch grant=winner.
  - If the beat's tlast=0: go to LOCKED.
  - If tlast=1, or USE_TLAST=0: stay in IDLE, pointer=(winner+1) mod INPUTS.
  - No rx valid: no handshake, state and pointer unchanged.
- FSM LOCKED:
  - rx[grant].tready = ca. All others = 0 regardless of their tvalid.
  - Beat handshake with tlast=1: go to IDLE, pointer=(grant+1) mod INPUTS.
  - Granted source deasserting tvalid mid-packet: grant is held and no other source is served (no timeout).
- Latency: beat accepted at cycle N appears on tx at cycle N+1.
- Throughput: 1 beat/cycle while tx.tready=1.
- Backpressure: tx.tready=0 with tx.tvalid=1 gives ca=0, so every rx.tready=0 that cycle.
- Simultaneous tx drain and rx load in one cycle is allowed (ca=1). Output is replaced with no bubble.
- Fairness: after any packet completes, its source has the lowest priority. With all sources continuously valid, grants cycle 0,1,…,INPUTS-1.
- INPUTS=1: pointer fixed at 0, grant always 0. Logic degenerates to a register slice with packet FSM.
- Unused optional fields (tkeep/tstrb/tlast disabled) drive constant 1 on tx.
- Reset asserted mid-packet: immediate return to reset values; the partial packet on tx is dropped.
- rx payload is sampled only on handshake. tx.tdest/tid/tuser are passed through unmodified.

Test Plan:
- Reset, INPUTS=4, all rx idle → tx.tvalid=0, all rx.tready=0. After release, rx[2] sends one beat tdata=0x5A, tlast=1 → tx.tvalid=1 with 0x5A exactly 1 cycle later; next IDLE search starts at 3.
- All 4 inputs continuously valid, 3-beat packets, tx.tready=1 → tx shows packets from sources 0,1,2,3,0 back-to-back, 12 beats in 12 cycles, no interleave.
- rx[1] mid-packet (beat 2 of 4) drops tvalid for 5 cycles while rx[0] and rx[3] are valid → rx[0].tready and rx[3].tready stay 0; rx[1] resumes and completes; next grant goes to 3.
- tx.tready toggles 1,0,0,1 during a 4-beat packet → no beat lost or duplicated; tx payload stable during stall cycles; all rx.tready=0 on stall cycles.
- USE_TLAST=0, rx[0] and rx[1] both always valid → tx beat sources alternate 0,1,0,1 per cycle.
- areset_n pulsed low after beat 2 of a 4-beat packet from rx[3] → tx.tvalid=0 asynchronously; after release the arbiter starts from IDLE with pointer 0, and a new rx[0] packet is granted first.
